noc_axi4_bridge_ser: RTL and testbench



---
 rtl/noc_axi4_bridge_pkg.sv | 157 +++++++++++++++
 rtl/noc_axi4_bridge_resp_hdr.sv | 40 ++++
 rtl/noc_axi4_bridge_ser.sv | 173 +++++++++++++++++
 tb/tb_noc_axi4_bridge_ser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_axi4_bridge_pkg.sv
// Shared definitions for the NoC-AXI4 bridge: message field positions,
// message type codes, size decoding, response mapping and payload byte swap.
package noc_axi4_bridge_pkg;

    // Channel and beat widths
    localparam int NOC_DATA_WIDTH      = 64;
    localparam int AXI4_DATA_WIDTH     = 512;
    localparam int MSG_HEADER_WIDTH    = 192;
    localparam int MSG_TYPE_WIDTH      = 8;
    localparam int MSG_LENGTH_WIDTH    = 8;
    localparam int MSG_DATA_SIZE_WIDTH = 3;
    localparam int FLIT_IDX_WIDTH      = 3;

    // Header flit 1 fields (bits 63:0 of the header)
    localparam int MSG_DST_CHIPID_HI = 63;
    localparam int MSG_DST_CHIPID_LO = 50;
    localparam int MSG_DST_X_HI      = 49;
    localparam int MSG_DST_X_LO      = 42;
    localparam int MSG_DST_Y_HI      = 41;
    localparam int MSG_DST_Y_LO      = 34;
    localparam int MSG_DST_FBITS_HI  = 33;
    localparam int MSG_DST_FBITS_LO  = 30;
    localparam int MSG_LENGTH_HI     = 29;
    localparam int MSG_LENGTH_LO     = 22;
    localparam int MSG_TYPE_HI       = 21;
    localparam int MSG_TYPE_LO       = 14;
    localparam int MSG_MSHRID_HI     = 13;
    localparam int MSG_MSHRID_LO     = 6;

    // Header flit 2 fields (bits 127:64 of the header)
    localparam int MSG_ADDR_HI       = 111;
    localparam int MSG_ADDR_LO       = 64;
    localparam int MSG_DATA_SIZE_HI  = 122;
    localparam int MSG_DATA_SIZE_LO  = 120;

    // Header flit 3 fields (bits 191:128 of the header)
    localparam int MSG_SRC_CHIPID_HI = 191;
    localparam int MSG_SRC_CHIPID_LO = 178;
    localparam int MSG_SRC_X_HI      = 177;
    localparam int MSG_SRC_X_LO      = 170;
    localparam int MSG_SRC_Y_HI      = 169;
    localparam int MSG_SRC_Y_LO      = 162;
    localparam int MSG_SRC_FBITS_HI  = 161;
    localparam int MSG_SRC_FBITS_LO  = 158;

    // Message types
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM         = 8'd19;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM        = 8'd20;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_NC_LOAD_REQ      = 8'd14;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_NC_STORE_REQ     = 8'd15;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK     = 8'd24;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM_ACK    = 8'd25;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_NC_LOAD_MEM_ACK  = 8'd26;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_NC_STORE_MEM_ACK = 8'd27;

    // Access size encodings
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_0B  = 3'd0;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_1B  = 3'd1;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_2B  = 3'd2;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_4B  = 3'd3;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_8B  = 3'd4;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_16B = 3'd5;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_32B = 3'd6;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_64B = 3'd7;

    // Full cache-line payload, in flits
    localparam logic [MSG_LENGTH_WIDTH-1:0] PAYLOAD_LEN = 8'd8;

    typedef enum logic [1:0] {
        SER_IDLE      = 2'd0,
        SER_SEND_HDR  = 2'd1,
        SER_SEND_DATA = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic [6:0] size_bytes;
        logic [5:0] offset;
    } size_info_t;

    // Decode the access size in bytes and the size-aligned line offset.
    function automatic size_info_t noc_extractSize(input logic [MSG_HEADER_WIDTH-1:0] header);
        size_info_t info;
        logic [5:0] align_mask;
        case (header[MSG_DATA_SIZE_HI:MSG_DATA_SIZE_LO])
            MSG_DATA_SIZE_0B:  begin info.size_bytes = 7'd0;  align_mask = 6'h00; end
            MSG_DATA_SIZE_1B:  begin info.size_bytes = 7'd1;  align_mask = 6'h00; end
            MSG_DATA_SIZE_2B:  begin info.size_bytes = 7'd2;  align_mask = 6'h01; end
            MSG_DATA_SIZE_4B:  begin info.size_bytes = 7'd4;  align_mask = 6'h03; end
            MSG_DATA_SIZE_8B:  begin info.size_bytes = 7'd8;  align_mask = 6'h07; end
            MSG_DATA_SIZE_16B: begin info.size_bytes = 7'd16; align_mask = 6'h0F; end
            MSG_DATA_SIZE_32B: begin info.size_bytes = 7'd32; align_mask = 6'h1F; end
            MSG_DATA_SIZE_64B: begin info.size_bytes = 7'd64; align_mask = 6'h3F; end
            default:           begin info.size_bytes = 7'd0;  align_mask = 6'h00; end
        endcase
        info.offset = header[MSG_ADDR_LO+5 -: 6] & ~align_mask;
        return info;
    endfunction

    // True for the request types this bridge knows how to answer.
    function automatic logic noc_isKnownReq(input logic [MSG_TYPE_WIDTH-1:0] req_type);
        logic known;
        case (req_type)
            MSG_TYPE_LOAD_MEM,
            MSG_TYPE_NC_LOAD_REQ,
            MSG_TYPE_STORE_MEM,
            MSG_TYPE_NC_STORE_REQ: known = 1'b1;
            default:               known = 1'b0;
        endcase
        return known;
    endfunction

    // Request type -> response type; unknown requests are answered as a store ack.
    function automatic logic [MSG_TYPE_WIDTH-1:0] noc_respType(input logic [MSG_TYPE_WIDTH-1:0] req_type);
        logic [MSG_TYPE_WIDTH-1:0] resp;
        case (req_type)
            MSG_TYPE_LOAD_MEM:     resp = MSG_TYPE_LOAD_MEM_ACK;
            MSG_TYPE_NC_LOAD_REQ:  resp = MSG_TYPE_NC_LOAD_MEM_ACK;
            MSG_TYPE_STORE_MEM:    resp = MSG_TYPE_STORE_MEM_ACK;
            MSG_TYPE_NC_STORE_REQ: resp = MSG_TYPE_NC_STORE_MEM_ACK;
            default:               resp = MSG_TYPE_STORE_MEM_ACK;
        endcase
        return resp;
    endfunction

    // Response payload length in flits; shared with the request path.
    function automatic logic [MSG_LENGTH_WIDTH-1:0] noc_respLength(input logic [MSG_TYPE_WIDTH-1:0] req_type,
                                                                   input logic [6:0]                size_bytes);
        logic [MSG_LENGTH_WIDTH-1:0] len;
        case (req_type)
            MSG_TYPE_LOAD_MEM:    len = PAYLOAD_LEN;
            MSG_TYPE_NC_LOAD_REQ: len = (size_bytes <= 7'd8) ? 8'd1 : PAYLOAD_LEN;
            default:              len = 8'd0;
        endcase
        return len;
    endfunction

    // Reverse byte order inside each access-size group of a 64-bit flit.
    function automatic logic [NOC_DATA_WIDTH-1:0] swapData(input logic [NOC_DATA_WIDTH-1:0]      data,
                                                           input logic [MSG_DATA_SIZE_WIDTH-1:0] size);
        logic [NOC_DATA_WIDTH-1:0] swapped;
        swapped = data;
        case (size)
            MSG_DATA_SIZE_2B: begin
                for (int b = 0; b < 8; b++) swapped[8*b +: 8] = data[8*(b ^ 1) +: 8];
            end
            MSG_DATA_SIZE_4B: begin
                for (int b = 0; b < 8; b++) swapped[8*b +: 8] = data[8*(b ^ 3) +: 8];
            end
            MSG_DATA_SIZE_8B, MSG_DATA_SIZE_16B, MSG_DATA_SIZE_32B, MSG_DATA_SIZE_64B: begin
                for (int b = 0; b < 8; b++) swapped[8*b +: 8] = data[8*(b ^ 7) +: 8];
            end
            default: swapped = data;
        endcase
        return swapped;
    endfunction

endpackage

// File: rtl/noc_axi4_bridge_resp_hdr.sv
// Combinational request-header to response-header conversion: routes the
// response back to the requester, maps the type and computes the length.
module noc_axi4_bridge_resp_hdr
    import noc_axi4_bridge_pkg::*;
(
    input  logic [MSG_HEADER_WIDTH-1:0]    i_req_hdr,
    output logic [NOC_DATA_WIDTH-1:0]      o_resp_hdr,
    output logic [MSG_LENGTH_WIDTH-1:0]    o_resp_len,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] o_req_size,
    output logic [FLIT_IDX_WIDTH-1:0]      o_slot,
    output logic                           o_type_err
);

    size_info_t                  w_info;
    logic [MSG_TYPE_WIDTH-1:0]   w_req_type;
    logic [MSG_LENGTH_WIDTH-1:0] w_len;

    // Build the response header; every field not listed stays zero.
    always_comb begin
        w_info     = noc_extractSize(i_req_hdr);
        w_req_type = i_req_hdr[MSG_TYPE_HI:MSG_TYPE_LO];
        w_len      = noc_respLength(w_req_type, w_info.size_bytes);

        o_resp_hdr = {NOC_DATA_WIDTH{1'b0}};
        o_resp_hdr[MSG_DST_CHIPID_HI:MSG_DST_CHIPID_LO] = i_req_hdr[MSG_SRC_CHIPID_HI:MSG_SRC_CHIPID_LO];
        o_resp_hdr[MSG_DST_X_HI:MSG_DST_X_LO]           = i_req_hdr[MSG_SRC_X_HI:MSG_SRC_X_LO];
        o_resp_hdr[MSG_DST_Y_HI:MSG_DST_Y_LO]           = i_req_hdr[MSG_SRC_Y_HI:MSG_SRC_Y_LO];
        o_resp_hdr[MSG_DST_FBITS_HI:MSG_DST_FBITS_LO]   = i_req_hdr[MSG_SRC_FBITS_HI:MSG_SRC_FBITS_LO];
        o_resp_hdr[MSG_LENGTH_HI:MSG_LENGTH_LO]         = w_len;
        o_resp_hdr[MSG_TYPE_HI:MSG_TYPE_LO]             = noc_respType(w_req_type);
        o_resp_hdr[MSG_MSHRID_HI:MSG_MSHRID_LO]         = i_req_hdr[MSG_MSHRID_HI:MSG_MSHRID_LO];

        o_resp_len = w_len;
        o_req_size = i_req_hdr[MSG_DATA_SIZE_HI:MSG_DATA_SIZE_LO];
        // 64-bit slot inside the line that a single-flit NC load returns
        o_slot     = FLIT_IDX_WIDTH'(w_info.offset >> 3);
        o_type_err = ~noc_isKnownReq(w_req_type);
    end

endmodule

// File: rtl/noc_axi4_bridge_ser.sv
// Response serializer: captures one completed transaction, then emits the
// response header flit followed by the payload flits, one per handshake.
module noc_axi4_bridge_ser
    import noc_axi4_bridge_pkg::*;
#(
    parameter logic SWAP_ENDIANESS    = 1'b0,
    parameter logic AXI2NOC_SER_ORDER = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [MSG_HEADER_WIDTH-1:0] header_in,
    input  logic [AXI4_DATA_WIDTH-1:0]  data_in,
    input  logic                        in_val,
    output logic                        in_rdy,
    output logic [NOC_DATA_WIDTH-1:0]   flit_out,
    output logic                        flit_out_val,
    input  logic                        flit_out_rdy,
    output logic                        err_type
);

    // Response fields computed from the live request header
    logic [NOC_DATA_WIDTH-1:0]      w_resp_hdr;
    logic [MSG_LENGTH_WIDTH-1:0]    w_resp_len;
    logic [MSG_DATA_SIZE_WIDTH-1:0] w_req_size;
    logic [FLIT_IDX_WIDTH-1:0]      w_slot;
    logic                           w_type_err;

    // Captured transaction and serializer state
    ser_state_e                     r_state;
    logic [AXI4_DATA_WIDTH-1:0]     r_data;
    logic [MSG_LENGTH_WIDTH-1:0]    r_len;
    logic [MSG_DATA_SIZE_WIDTH-1:0] r_size;
    logic [FLIT_IDX_WIDTH-1:0]      r_slot;
    logic [FLIT_IDX_WIDTH-1:0]      r_idx;
    logic [NOC_DATA_WIDTH-1:0]      r_flit_out;
    logic                           r_flit_val;
    logic                           r_in_rdy;
    logic                           r_err;

    // Next payload flit to load into the output register
    logic [FLIT_IDX_WIDTH-1:0]      w_load_idx;
    logic [FLIT_IDX_WIDTH-1:0]      w_sel_slot;
    logic [FLIT_IDX_WIDTH-1:0]      w_chunk;
    logic [NOC_DATA_WIDTH-1:0]      w_raw;
    logic [NOC_DATA_WIDTH-1:0]      w_payload;
    logic                           w_last;

    noc_axi4_bridge_resp_hdr u_resp_hdr (
        .i_req_hdr  (header_in),
        .o_resp_hdr (w_resp_hdr),
        .o_resp_len (w_resp_len),
        .o_req_size (w_req_size),
        .o_slot     (w_slot),
        .o_type_err (w_type_err)
    );

    // Select and format the payload flit that follows the one on the output.
    always_comb begin
        if (r_state == SER_SEND_HDR) begin
            w_load_idx = 3'd0;
        end else begin
            w_load_idx = r_idx + 3'd1;
        end

        // A single-flit response carries the addressed slot, not slot 0
        if (r_len == 8'd1) begin
            w_sel_slot = r_slot;
        end else begin
            w_sel_slot = w_load_idx;
        end

        if (AXI2NOC_SER_ORDER != 1'b0) begin
            w_chunk = 3'd7 - w_sel_slot;
        end else begin
            w_chunk = w_sel_slot;
        end

        w_raw = r_data[{w_chunk, 6'd0} +: NOC_DATA_WIDTH];

        if (SWAP_ENDIANESS != 1'b0) begin
            w_payload = swapData(w_raw, r_size);
        end else begin
            w_payload = w_raw;
        end

        w_last = ({5'd0, r_idx} == (r_len - 8'd1));
    end

    // Serializer FSM with registered flit, valid, ready and error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= SER_IDLE;
            r_data     <= {AXI4_DATA_WIDTH{1'b0}};
            r_len      <= 8'd0;
            r_size     <= 3'd0;
            r_slot     <= 3'd0;
            r_idx      <= 3'd0;
            r_flit_out <= {NOC_DATA_WIDTH{1'b0}};
            r_flit_val <= 1'b0;
            r_in_rdy   <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    r_err <= 1'b0;
                    if (in_val) begin
                        r_data     <= data_in;
                        r_len      <= w_resp_len;
                        r_size     <= w_req_size;
                        r_slot     <= w_slot;
                        r_idx      <= 3'd0;
                        r_flit_out <= w_resp_hdr;
                        r_flit_val <= 1'b1;
                        r_in_rdy   <= 1'b0;
                        r_err      <= w_type_err;
                        r_state    <= SER_SEND_HDR;
                    end else begin
                        r_state    <= SER_IDLE;
                    end
                end
                SER_SEND_HDR: begin
                    r_err <= 1'b0;
                    if (flit_out_rdy) begin
                        if (r_len != 8'd0) begin
                            r_flit_out <= w_payload;
                            r_idx      <= 3'd0;
                            r_state    <= SER_SEND_DATA;
                        end else begin
                            r_flit_out <= {NOC_DATA_WIDTH{1'b0}};
                            r_flit_val <= 1'b0;
                            r_in_rdy   <= 1'b1;
                            r_state    <= SER_IDLE;
                        end
                    end else begin
                        r_state <= SER_SEND_HDR;
                    end
                end
                SER_SEND_DATA: begin
                    r_err <= 1'b0;
                    if (flit_out_rdy) begin
                        if (w_last) begin
                            r_flit_out <= {NOC_DATA_WIDTH{1'b0}};
                            r_flit_val <= 1'b0;
                            r_in_rdy   <= 1'b1;
                            r_idx      <= 3'd0;
                            r_state    <= SER_IDLE;
                        end else begin
                            r_flit_out <= w_payload;
                            r_idx      <= w_load_idx;
                            r_state    <= SER_SEND_DATA;
                        end
                    end else begin
                        r_state <= SER_SEND_DATA;
                    end
                end
                default: begin
                    r_flit_out <= {NOC_DATA_WIDTH{1'b0}};
                    r_flit_val <= 1'b0;
                    r_in_rdy   <= 1'b1;
                    r_err      <= 1'b0;
                    r_idx      <= 3'd0;
                    r_state    <= SER_IDLE;
                end
            endcase
        end
    end

    assign in_rdy       = r_in_rdy;
    assign flit_out     = r_flit_out;
    assign flit_out_val = r_flit_val;
    assign err_type     = r_err;

endmodule

// File: tb/tb_noc_axi4_bridge_ser.sv
// Bench for noc_axi4_bridge_ser: two instances (plain order / reversed order
// with byte swap) share stimulus and are checked against a packet-level model.
module tb_noc_axi4_bridge_ser;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [191:0] header_in;
    logic [511:0] data_in;
    logic         in_val;
    logic         flit_out_rdy;

    logic         in_rdy0, val0, err0;
    logic [63:0]  flit0;
    logic         in_rdy1, val1, err1;
    logic [63:0]  flit1;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           started = 1'b0;
    bit           rnd_done = 1'b0;
    logic         m_err = 1'b0;
    logic [63:0]  q0[$];
    logic [63:0]  q1[$];

    always #5 clk = ~clk;

    noc_axi4_bridge_ser #(.SWAP_ENDIANESS(1'b0), .AXI2NOC_SER_ORDER(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in),
        .in_val(in_val), .in_rdy(in_rdy0), .flit_out(flit0), .flit_out_val(val0),
        .flit_out_rdy(flit_out_rdy), .err_type(err0)
    );

    noc_axi4_bridge_ser #(.SWAP_ENDIANESS(1'b1), .AXI2NOC_SER_ORDER(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .header_in(header_in), .data_in(data_in),
        .in_val(in_val), .in_rdy(in_rdy1), .flit_out(flit1), .flit_out_val(val1),
        .flit_out_rdy(flit_out_rdy), .err_type(err1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] mk_hdr(input logic [7:0] t, input logic [2:0] sz, input logic [47:0] addr,
                                            input logic [7:0] mshr, input logic [13:0] schip, input logic [7:0] sx,
                                            input logic [7:0] sy, input logic [3:0] sf, input logic [41:0] junk);
        logic [191:0] h;
        h = '0;
        h[63:22]   = junk;
        h[21:14]   = t;
        h[13:6]    = mshr;
        h[111:64]  = addr;
        h[122:120] = sz;
        h[191:178] = schip;
        h[177:170] = sx;
        h[169:162] = sy;
        h[161:158] = sf;
        return h;
    endfunction

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] d;
        for (int k = 0; k < 8; k++) d[64*k +: 64] = base + 64'(k);
        return d;
    endfunction

    function automatic bit known_type(input logic [7:0] t);
        return (t == 8'd19) || (t == 8'd14) || (t == 8'd20) || (t == 8'd15);
    endfunction

    function automatic int exp_len(input logic [191:0] h);
        if (h[21:14] == 8'd19) return 8;
        if (h[21:14] == 8'd14) return (h[122:120] <= 3'd4) ? 1 : 8;
        return 0;
    endfunction

    function automatic logic [63:0] exp_hdr(input logic [191:0] h);
        logic [7:0] rt;
        if (h[21:14] == 8'd19)      rt = 8'd24;
        else if (h[21:14] == 8'd14) rt = 8'd26;
        else if (h[21:14] == 8'd15) rt = 8'd27;
        else                        rt = 8'd25;
        return (64'(h[191:178]) << 50) | (64'(h[177:170]) << 42) | (64'(h[169:162]) << 34) |
               (64'(h[161:158]) << 30) | (64'(exp_len(h)) << 22) | (64'(rt) << 14) | (64'(h[13:6]) << 6);
    endfunction

    function automatic logic [63:0] exp_payload(input logic [191:0] h, input logic [511:0] d,
                                                input bit swap, input bit order, input int i);
        int slot, ci, g;
        logic [63:0] v, r;
        slot = (exp_len(h) == 1) ? int'(h[69:67]) : i;
        ci   = order ? 7 - slot : slot;
        v    = d[64*ci +: 64];
        if (!swap) return v;
        case (h[122:120])
            3'd2:    g = 2;
            3'd3:    g = 4;
            3'd4, 3'd5, 3'd6, 3'd7: g = 8;
            default: g = 1;
        endcase
        for (int b = 0; b < 8; b++) r[8*b +: 8] = v[8*((b / g) * g + (g - 1 - b % g)) +: 8];
        return r;
    endfunction

    // Packet-level model: one pending packet, popped one flit per accepted cycle
    initial begin
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                m_err = 1'b0;
            end else begin
                m_err = 1'b0;
                if (q0.size() != 0) begin
                    if (flit_out_rdy) begin
                        void'(q0.pop_front());
                        void'(q1.pop_front());
                    end
                end else if (in_val) begin
                    m_err = !known_type(header_in[21:14]);
                    q0.push_back(exp_hdr(header_in));
                    q1.push_back(exp_hdr(header_in));
                    for (int i = 0; i < exp_len(header_in); i++) begin
                        q0.push_back(exp_payload(header_in, data_in, 1'b0, 1'b0, i));
                        q1.push_back(exp_payload(header_in, data_in, 1'b1, 1'b1, i));
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("val0", {63'd0, val0}, 64'(q0.size() != 0));
                chk("val1", {63'd0, val1}, 64'(q1.size() != 0));
                chk("in_rdy0", {63'd0, in_rdy0}, 64'(q0.size() == 0));
                chk("in_rdy1", {63'd0, in_rdy1}, 64'(q1.size() == 0));
                chk("err0", {63'd0, err0}, {63'd0, m_err});
                chk("err1", {63'd0, err1}, {63'd0, m_err});
                if (q0.size() != 0) chk("flit0", flit0, q0[0]);
                if (q1.size() != 0) chk("flit1", flit1, q1[0]);
            end
        end
    end

    task automatic send(input logic [191:0] h, input logic [511:0] d);
        int t;
        t = 0;
        while (in_rdy0 !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("send_wait", 64'(t < 3000), 64'd1);
        header_in = h;
        data_in   = d;
        in_val    = 1'b1;
        @(negedge clk);
        in_val    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] line;
        logic [7:0]   tlist [6];
        int           t;
        tlist = '{8'd19, 8'd14, 8'd20, 8'd15, 8'h7F, 8'h02};
        line  = mk_line(64'h0011_2233_4455_6600);

        rst_n = 1'b0; in_val = 1'b0; header_in = '0; data_in = '0; flit_out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_val", {63'd0, val0}, 64'd0);
        chk("rst_flit", flit0, 64'd0);
        chk("rst_err", {63'd0, err0}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", {63'd0, in_rdy0}, 64'd1);

        // Full-line load, dst 2/3, mshr 5
        send(mk_hdr(8'd19, 3'd7, 48'h0, 8'd5, 14'd0, 8'd2, 8'd3, 4'd0, 42'd0), line);
        chk("ld_hdr0", flit0, 64'h0000_080C_0206_0140);
        chk("ld_hdr1", flit1, 64'h0000_080C_0206_0140);
        @(negedge clk);
        chk("ld_p0_0", flit0, 64'h0011_2233_4455_6600);
        chk("ld_p0_1", flit1, 64'h0766_5544_3322_1100);

        // NC store, mshr 9, src 1/1
        send(mk_hdr(8'd15, 3'd3, 48'h40, 8'd9, 14'd0, 8'd1, 8'd1, 4'd0, 42'd0), line);
        chk("ncst_hdr", flit0, 64'h0000_0404_0006_C240);
        @(negedge clk);
        chk("ncst_idle_val", {63'd0, val0}, 64'd0);
        chk("ncst_idle_rdy", {63'd0, in_rdy0}, 64'd1);

        // NC load, 4 B at 0x18: slot 3 (slot 4 in reversed order, 4-byte swapped)
        send(mk_hdr(8'd14, 3'd3, 48'h18, 8'd2, 14'd0, 8'd0, 8'd0, 4'd0, 42'd0), line);
        chk("ncld_hdr", flit0, 64'h0000_0000_0046_8080);
        @(negedge clk);
        chk("ncld_p0", flit0, 64'h0011_2233_4455_6603);
        chk("ncld_p1", flit1, 64'h3322_1100_0466_5544);

        // Unknown request type
        send(mk_hdr(8'h7F, 3'd0, 48'h0, 8'd1, 14'd0, 8'd0, 8'd0, 4'd0, 42'd0), line);
        chk("unk_hdr", flit0, 64'h0000_0000_0006_4040);
        chk("unk_err", {63'd0, err0}, 64'd1);
        @(negedge clk);
        chk("unk_err_clr", {63'd0, err0}, 64'd0);

        // Reset while payload flit 4 is on the output
        send(mk_hdr(8'd19, 3'd7, 48'h0, 8'd3, 14'd0, 8'd4, 8'd5, 4'd0, 42'd0), line);
        repeat (5) @(negedge clk);
        chk("mid_p4", flit0, 64'h0011_2233_4455_6604);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_val0", {63'd0, val0}, 64'd0);
        chk("mid_rst_val1", {63'd0, val1}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy", {63'd0, in_rdy0}, 64'd1);
        chk("mid_rel_val", {63'd0, val0}, 64'd0);

        // Mixed traffic under random backpressure
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    logic [511:0] d;
                    logic [191:0] h;
                    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom();
                    h = mk_hdr(tlist[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                               {16'($urandom()), 32'($urandom())}, 8'($urandom()), 14'($urandom()),
                               8'($urandom()), 8'($urandom()), 4'($urandom()),
                               {10'($urandom()), 32'($urandom())});
                    send(h, d);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    flit_out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        flit_out_rdy = 1'b1;
        t = 0;
        while (q0.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(q0.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
